// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: bus widths, reset PC, bus layouts
// and the BTB 2-bit counter encoding.
package if_stage_pkg;

  localparam int          ID_TO_IF_BUS_WD  = 99;
  localparam int          IF_TO_IPD_BUS_WD = 96;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  // Redirect and branch-unit training information coming back from ID.
  typedef struct packed {
    logic        br_taken_cancel;
    logic [31:0] pc_from_id;
    logic        bu_valid;
    logic        bu_taken;
    logic [31:0] bu_pc;
    logic [31:0] bu_target;
  } id_to_if_t;

  // What pre-decode receives; the instruction word comes from the RAM instead.
  typedef struct packed {
    logic [31:0] pred_pc;
    logic [31:0] inst_pc;
    logic [31:0] rsvd;
  } if_to_ipd_t;

  // MSB of the counter is the predicted direction.
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

endpackage

// File: rtl/if_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; training is applied at the clock edge, so a
// lookup in the same cycle as a training write sees the old contents.
module branch_target_buffer
  import if_stage_pkg::*;
#(
  parameter int BTB_IDX_W = 4,
  parameter int BTB_TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        taken,
  output logic [31:0] target,
  input  logic        upd_valid,
  input  logic        upd_taken,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_LSB = BTB_IDX_W + 2;

  logic [ENTRIES-1:0]   valid_q;
  ctr_t                 ctr_q    [ENTRIES];
  logic [BTB_TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];

  logic [BTB_IDX_W-1:0] lk_idx, up_idx;
  logic [BTB_TAG_W-1:0] lk_tag, up_tag;
  logic                 up_hit;
  logic                 unused_pc_bits;

  function automatic ctr_t ctr_step(input ctr_t c, input logic tk);
    if (tk) return (c == CTR_STRONG_T)  ? c : ctr_t'(c + 2'd1);
    else    return (c == CTR_STRONG_NT) ? c : ctr_t'(c - 2'd1);
  endfunction

  assign lk_idx = lookup_pc[BTB_IDX_W+1:2];
  assign lk_tag = lookup_pc[TAG_LSB +: BTB_TAG_W];
  assign up_idx = upd_pc[BTB_IDX_W+1:2];
  assign up_tag = upd_pc[TAG_LSB +: BTB_TAG_W];

  // Only the index and tag fields of the PCs select an entry.
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign taken  = ctr_q[lk_idx][1];
  assign target = target_q[lk_idx];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Valid bits and counters: cleared on reset, trained on resolved branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WEAK_NT;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken);
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // Tag and target storage.
  // NOTE: no reset here on purpose -- an entry is meaningless until its valid
  // bit is set, so clearing these arrays would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      target_q[up_idx] <= upd_target;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the synchronous
// instruction RAM and predicts the next PC through the BTB.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BTB_IDX_W = 4,
  parameter int          BTB_TAG_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
  output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  input  logic                        IPD_allow_in,
  output logic                        IF_to_IPD_valid,
  output logic                        inst_ram_en,
  output logic [3:0]                  inst_ram_we,
  output logic [31:0]                 inst_ram_addr,
  output logic [31:0]                 inst_ram_w_data
);

  id_to_if_t   id_bus;
  if_to_ipd_t  ipd_bus;
  logic [31:0] fetch_pc;
  logic [31:0] pred_pc;
  logic        if_valid;
  logic        fire;
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target;

  assign id_bus = id_to_if_t'(ID_to_IF_bus);

  branch_target_buffer #(
    .BTB_IDX_W (BTB_IDX_W),
    .BTB_TAG_W (BTB_TAG_W)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (fetch_pc),
    .hit        (btb_hit),
    .taken      (btb_taken),
    .target     (btb_target),
    .upd_valid  (id_bus.bu_valid),
    .upd_taken  (id_bus.bu_taken),
    .upd_pc     (id_bus.bu_pc),
    .upd_target (id_bus.bu_target)
  );

  // Sequential fallthrough wraps naturally at 32 bits.
  assign pred_pc = (btb_hit && btb_taken) ? btb_target : fetch_pc + 32'd4;

  assign IF_to_IPD_valid = if_valid && !id_bus.br_taken_cancel && !reset;
  assign fire            = IF_to_IPD_valid && IPD_allow_in;

  // Enable only on fire so the RAM output holds the stalled instruction.
  assign inst_ram_en     = fire;
  assign inst_ram_we     = 4'b0;
  assign inst_ram_addr   = fetch_pc;
  assign inst_ram_w_data = 32'b0;

  assign ipd_bus.pred_pc = pred_pc;
  assign ipd_bus.inst_pc = fetch_pc;
  assign ipd_bus.rsvd    = 32'b0;
  assign IF_to_IPD_bus   = ipd_bus;

  // Fetch PC: reset, then redirect from ID, then advance on fire, else hold.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
    end else begin
      if_valid <= 1'b1;
      if (id_bus.br_taken_cancel) fetch_pc <= id_bus.pc_from_id;
      else if (fire)              fetch_pc <= pred_pc;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- First pipeline stage. Owns the fetch PC and drives the synchronous instruction RAM read port.
- Predicts the next PC with a small direct-mapped BTB that uses 2-bit counters.
- Sends {pred_PC, inst_PC} to the pre-decode stage; the instruction word itself arrives there from the RAM one cycle later.
- Accepts redirects and BTB training from ID.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- BTB_IDX_W, 4, log2 of BTB entries (16); index = PC[BTB_IDX_W+1:2].
- BTB_TAG_W, 8, tag = PC[BTB_IDX_W+2+BTB_TAG_W-1 : BTB_IDX_W+2].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ID_to_IF_bus  in  `ID_TO_IF_BUS_WD (99)  {br_taken_cancel[98], PC_fromID[97:66], bu_valid[65], bu_taken[64], bu_PC[63:32], bu_target[31:0]}.
- IF_to_IPD_bus  out  `IF_TO_IPD_BUS_WD (96)  {pred_PC[95:64], inst_PC[63:32], 32'b0[31:0]}.
- IPD_allow_in  in  1  pre-decode can accept.
- IF_to_IPD_valid  out  1  bus valid this cycle.
- inst_ram_en  out  1  RAM read enable; RAM output holds when low.
- inst_ram_we  out  4  tied 4'b0.
- inst_ram_addr  out  32  byte address = fetch_PC.
- inst_ram_w_data  out  32  tied 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: fetch_PC = RESET_PC, IF_valid = 0, all BTB valid = 0, counters = 2'b01.
- Outputs while reset is held: IF_to_IPD_valid = 0 and inst_ram_en = 0.
- IF_valid goes to 1 on the first clock edge after reset deasserts and stays 1; the stage always has a fetch address.
- IF_to_IPD_valid = IF_valid & ~br_taken_cancel.
- Fire = IF_to_IPD_valid & IPD_allow_in.
- inst_ram_en = fire, inst_ram_addr = fetch_PC. The instruction for inst_PC is on inst_ram_r_data in the cycle IPD holds that PC.
- While IPD stalls, en is low, so the RAM output stays stable for the stalled instruction.
- PC update, in priority order:
  - reset
  - br_taken_cancel: fetch_PC <= PC_fromID; nothing is sent that cycle.
  - fire: fetch_PC <= pred_PC.
  - otherwise hold.
- Prediction is combinational from fetch_PC:
  - hit = valid[idx] & (tag[idx] == PC tag).
  - pred_PC = (hit & ctr[idx][1]) ? btb_target[idx] : fetch_PC + 4. The +4 is 32-bit and wraps.
- inst_PC = fetch_PC; the low 32 bits of IF_to_IPD_bus are zero.
- BTB training, only when bu_valid, applied at the clock edge:
  - Tag hit: ctr saturates +1 if bu_taken, -1 otherwise (clamped 2'b00..2'b11). If bu_taken, target <= bu_target.
  - Tag miss and bu_taken: allocate/replace with valid = 1, tag, target = bu_target, ctr = 2'b10.
  - Tag miss and not taken: no change.
- Same-cycle read and train of the same index: the prediction uses the pre-edge contents; there is no write-through bypass.
- br_taken_cancel together with bu_valid: both take effect.
- Reset mid-stall or mid-redirect: reset wins and the BTB is fully invalidated.
- Misaligned PC_fromID is passed through unchanged; ID is responsible for alignment.

Decomposition:
- Shared header (myCPU.h): `ID_TO_IF_BUS_WD = 99; `IF_TO_IPD_BUS_WD = 96 (already present); RESET_PC constant.
- One sub-module, branch_target_buffer:
  - Parameters BTB_IDX_W and BTB_TAG_W.
  - Combinational lookup port: PC in; hit, taken, target out.
  - Synchronous update port.
  - Contains the counter saturation logic.
- if_stage keeps the PC register, the handshake and the RAM drive.

Test Plan:
- Reset, then IPD_allow_in = 1 with BTB empty -> successive fires present inst_PC 0x1C000000, 0x1C000004, 0x1C000008; pred_PC = inst_PC + 4; inst_ram_en = 1 each cycle.
- IPD_allow_in = 0 for 3 cycles at inst_PC 0x1C000008 -> fetch_PC holds; inst_ram_en = 0; IF_to_IPD_valid stays 1; fetching resumes at 0x1C000008 when allow_in returns.
- br_taken_cancel = 1 with PC_fromID = 0x1C000100 -> IF_to_IPD_valid = 0 that cycle; next cycle inst_PC = 0x1C000100.
- Train bu_PC = 0x1C000010, target 0x1C000040, taken -> ctr = 10; the next fetch of 0x1C000010 gives pred_PC = 0x1C000040.
  - Two not-taken trainings -> ctr = 00; pred_PC = 0x1C000014.
- Aliasing: train 0x1C000010 taken, then fetch 0x1C000410 (same index, different tag) -> miss, pred_PC = 0x1C000414.
  - Training 0x1C000410 not-taken -> the entry for 0x1C000010 is unchanged.
- Four taken trainings of one PC -> ctr saturates at 11, then one not-taken -> 10, still predicted taken.
  - Assert reset mid-sequence -> the BTB misses for that PC afterwards.
